// File: rtl/reg_file_8x8.sv
// ============================================================================
//  Module      : reg_file_8x8
//  Description : NUM_REGS x DATA_W register file, two combinational read ports,
//                one synchronous write port, written-since-clear mask.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_file_8x8 #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int BYPASS = 0
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [DATA_W-1:0]      IN,
  input  logic [ADDR_W-1:0]      INADDRESS,
  input  logic                   WRITE,
  input  logic [ADDR_W-1:0]      OUT1ADDRESS,
  input  logic [ADDR_W-1:0]      OUT2ADDRESS,
  input  logic                   CLEAR_MASK,
  output logic [DATA_W-1:0]      OUT1,
  output logic [DATA_W-1:0]      OUT2,
  output logic [(2**ADDR_W)-1:0] WRITTEN_MASK
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] mask_q;
  logic [NUM_REGS-1:0] mask_d;

  // Write wins over a same-edge mask clear for the addressed bit.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    mask_d = CLEAR_MASK ? '0 : mask_q;
    if (WRITE) begin
      regs_d[INADDRESS] = IN;
      mask_d[INADDRESS] = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      mask_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      mask_q <= mask_d;
    end
  end

  generate
    if (BYPASS != 0) begin : g_bypass
      logic w_hit1;
      logic w_hit2;
      assign w_hit1 = WRITE && !RESET && (OUT1ADDRESS == INADDRESS);
      assign w_hit2 = WRITE && !RESET && (OUT2ADDRESS == INADDRESS);
      assign OUT1   = w_hit1 ? IN : regs_q[OUT1ADDRESS];
      assign OUT2   = w_hit2 ? IN : regs_q[OUT2ADDRESS];
    end else begin : g_no_bypass
      assign OUT1 = regs_q[OUT1ADDRESS];
      assign OUT2 = regs_q[OUT2ADDRESS];
    end
  endgenerate

  assign WRITTEN_MASK = mask_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_file_8x8.sv
// ============================================================================
//  Module      : tb_reg_file_8x8
//  Description : Directed bench for reg_file_8x8, plain and forwarding builds.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_reg_file_8x8;

  logic       CLK;
  logic       RESET;
  logic [7:0] IN;
  logic [2:0] INADDRESS;
  logic       WRITE;
  logic [2:0] OUT1ADDRESS;
  logic [2:0] OUT2ADDRESS;
  logic       CLEAR_MASK;
  logic [7:0] OUT1, OUT2, WRITTEN_MASK;
  logic [7:0] B_OUT1, B_OUT2, B_WRITTEN_MASK;

  int n_chk;
  int n_fail;

  reg_file_8x8 #(.DATA_W(8), .ADDR_W(3), .BYPASS(0)) dut (
    .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
    .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS), .CLEAR_MASK(CLEAR_MASK),
    .OUT1(OUT1), .OUT2(OUT2), .WRITTEN_MASK(WRITTEN_MASK)
  );

  reg_file_8x8 #(.DATA_W(8), .ADDR_W(3), .BYPASS(1)) dut_b (
    .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
    .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS), .CLEAR_MASK(CLEAR_MASK),
    .OUT1(B_OUT1), .OUT2(B_OUT2), .WRITTEN_MASK(B_WRITTEN_MASK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    RESET = 1'b1; IN = '0; INADDRESS = '0; WRITE = 1'b0;
    OUT1ADDRESS = '0; OUT2ADDRESS = '0; CLEAR_MASK = 1'b0;

    // Reset state, before any clock edge
    #2;
    chk("rst_out1", OUT1, 8'h00);
    chk("rst_out2", OUT2, 8'h00);
    chk("rst_mask", WRITTEN_MASK, 8'h00);
    @(negedge CLK);
    RESET = 1'b0;

    // Write 0x5A to r3
    @(negedge CLK);
    WRITE = 1'b1; IN = 8'h5A; INADDRESS = 3'd3;
    tick();
    WRITE = 1'b0; OUT1ADDRESS = 3'd3;
    #1;
    chk("wr_r3_out1", OUT1, 8'h5A);
    chk("wr_r3_mask", WRITTEN_MASK, 8'h08);
    chk("wr_r3_out1_b", B_OUT1, 8'h5A);

    // r7 = 0xFF then r0 = 0x01 on consecutive edges
    @(negedge CLK);
    WRITE = 1'b1; IN = 8'hFF; INADDRESS = 3'd7;
    @(negedge CLK);
    IN = 8'h01; INADDRESS = 3'd0;
    @(negedge CLK);
    WRITE = 1'b0; OUT1ADDRESS = 3'd7; OUT2ADDRESS = 3'd0;
    #1;
    chk("r7_out1", OUT1, 8'hFF);
    chk("r0_out2", OUT2, 8'h01);
    chk("r7r0_mask", WRITTEN_MASK, 8'h89);
    OUT1ADDRESS = 3'd3; OUT2ADDRESS = 3'd1;
    #1;
    chk("r3_kept", OUT1, 8'h5A);
    chk("r1_untouched", OUT2, 8'h00);
    OUT2ADDRESS = 3'd3;
    #1;
    chk("same_addr_out1", OUT1, 8'h5A);
    chk("same_addr_out2", OUT2, 8'h5A);

    // Forwarding vs. old value before the edge
    @(negedge CLK);
    WRITE = 1'b1; IN = 8'h33; INADDRESS = 3'd2; OUT2ADDRESS = 3'd2;
    #1;
    chk("nobyp_pre_edge", OUT2, 8'h00);
    chk("byp_pre_edge", B_OUT2, 8'h33);
    chk("byp_other_port", B_OUT1, 8'h5A);
    tick();
    chk("nobyp_post_edge", OUT2, 8'h33);
    chk("byp_post_edge", B_OUT2, 8'h33);
    chk("r2_mask", WRITTEN_MASK, 8'h8D);

    // Clear mask and write r5 on the same edge
    @(negedge CLK);
    WRITE = 1'b1; IN = 8'h77; INADDRESS = 3'd5; CLEAR_MASK = 1'b1;
    tick();
    chk("clr_wr_mask", WRITTEN_MASK, 8'h20);
    chk("clr_wr_mask_b", B_WRITTEN_MASK, 8'h20);
    @(negedge CLK);
    WRITE = 1'b0; CLEAR_MASK = 1'b1; OUT1ADDRESS = 3'd5;
    tick();
    chk("clr_only_mask", WRITTEN_MASK, 8'h00);
    chk("clr_keeps_data", OUT1, 8'h77);
    CLEAR_MASK = 1'b0;

    // WRITE=0 leaves storage alone
    @(negedge CLK);
    IN = 8'h55; INADDRESS = 3'd1; OUT2ADDRESS = 3'd1;
    tick();
    chk("no_write_r1", OUT2, 8'h00);
    chk("no_write_mask", WRITTEN_MASK, 8'h00);

    // Mid-cycle reset pulse, no clock edge involved
    @(negedge CLK);
    #2;
    RESET = 1'b1;
    #1;
    chk("async_rst_out1", OUT1, 8'h00);
    chk("async_rst_out2", OUT2, 8'h00);
    chk("async_rst_r7", dut.regs_q[7], 8'h00);
    RESET = 1'b0;

    // Rebuild one written reg so the mask is nonzero, then abort a write
    @(negedge CLK);
    WRITE = 1'b1; IN = 8'hC3; INADDRESS = 3'd6; OUT2ADDRESS = 3'd6;
    tick();
    chk("r6_written", OUT2, 8'hC3);
    chk("r6_mask", WRITTEN_MASK, 8'h40);
    @(negedge CLK);
    IN = 8'hAA; INADDRESS = 3'd4; OUT1ADDRESS = 3'd4;
    #1;
    RESET = 1'b1;
    #1;
    chk("rst_mask_immediate", WRITTEN_MASK, 8'h00);
    chk("rst_r6_immediate", OUT2, 8'h00);
    chk("rst_blocks_bypass", B_OUT1, 8'h00);
    tick();
    chk("rst_write_ignored", OUT1, 8'h00);
    @(negedge CLK);
    WRITE = 1'b0; RESET = 1'b0;
    #1;
    chk("lost_write_r4", OUT1, 8'h00);
    chk("lost_write_mask", WRITTEN_MASK, 8'h00);
    tick();
    chk("lost_write_r4_later", OUT1, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
